// File: rtl/audio_pkg.sv
// Shared types for the audio frame scheduler: default sample width, sample type, FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package audio_pkg;

    localparam int DEF_SAMPLE_WIDTH = 16;

    typedef logic [DEF_SAMPLE_WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2
    } sched_state_t;

endpackage

// File: rtl/frame_ring_ram.sv
// Simple dual-port ring storage: one write port, one registered read port.
// Latency: rd_data valid one cycle after rd_en; it holds its value while rd_en is low.
// Backpressure: none; the caller stalls by withholding rd_en.
//
// Ports: clk, rst_n (async, active-low, clears only the read register),
//        wr_en/wr_addr/wr_data write port, rd_en/rd_addr read request, rd_data read result.
module frame_ring_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array has no reset; its contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register doubles as the scheduler's output data stage, so it
    // is reset and only updates on an issued read (holds during stalls).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/audio_frame_scheduler.sv
// Buffers I2S samples in a ring and streams the latest WINDOW_SIZE samples every HOP_SIZE samples.
// Latency: trigger sample in cycle T -> busy_out at T+1 -> first beat valid at T+2; one beat/cycle when ready.
// Backpressure: frame_ready_in low holds the beat stable; triggers arriving mid-frame are dropped and flag overrun_out.
//
// Ports: clk_in, rst_in (async active-low); sample_in/sample_valid_in from I2S;
//        enable_in gates triggers; clear_overrun_in clears the sticky overrun flag;
//        frame_data_out/frame_valid_out/frame_ready_in/frame_first_out/frame_last_out beat stream;
//        busy_out frame in progress; overrun_out sticky dropped-trigger flag.
// Optional: define AUDIO_FRAME_INDEX_EN to add frame_index_out (16-bit count of frames started).
module audio_frame_scheduler
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int WINDOW_SIZE  = 2048,
    parameter int HOP_SIZE     = 512
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid_in,
    input  logic                    enable_in,
    input  logic                    clear_overrun_in,
    output logic [SAMPLE_WIDTH-1:0] frame_data_out,
    output logic                    frame_valid_out,
    input  logic                    frame_ready_in,
    output logic                    frame_first_out,
    output logic                    frame_last_out,
    output logic                    busy_out,
    output logic                    overrun_out
`ifdef AUDIO_FRAME_INDEX_EN
    ,
    output logic [15:0]             frame_index_out
`endif
);

    localparam int DEPTH = 2 * WINDOW_SIZE;
    localparam int AW    = $clog2(DEPTH);
    localparam int FW    = $clog2(WINDOW_SIZE + 1);
    localparam int HW    = $clog2(HOP_SIZE + 1);

    localparam logic [FW-1:0] FILL_FULL = FW'(WINDOW_SIZE);
    localparam logic [FW-1:0] LAST_IDX  = FW'(WINDOW_SIZE - 1);
    localparam logic [HW-1:0] HOP_FULL  = HW'(HOP_SIZE);

    sched_state_t  state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [FW-1:0] fill_cnt;
    logic [FW-1:0] rd_cnt;     // reads issued in the current frame
    logic [HW-1:0] hop_cnt;

    logic trig;
    logic trig_accept;
    logic trig_drop;
    logic rd_en;
    logic beat_done;
    logic last_done;

    // A trigger is the sample that completes the first window, then every
    // HOP_SIZE-th sample after that.
    always_comb begin
        trig = 1'b0;
        if (sample_valid_in) begin
            if (fill_cnt != FILL_FULL) begin
                trig = (fill_cnt + FW'(1)) == FILL_FULL;
            end else begin
                trig = (hop_cnt + HW'(1)) == HOP_FULL;
            end
        end
    end

    // enable_in low suppresses silently; only enabled triggers can overrun.
    assign trig_accept = trig && enable_in && (state == IDLE);
    assign trig_drop   = trig && enable_in && (state != IDLE);

    assign beat_done = frame_valid_out && frame_ready_in;
    assign last_done = beat_done && frame_last_out;

    // Refill the output stage only when it is empty or draining this cycle.
    assign rd_en = (state != IDLE) && (!frame_valid_out || frame_ready_in) &&
                   (rd_cnt != FILL_FULL);

    frame_ring_ram #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_WIDTH)
    ) u_ram (
        .clk     (clk_in),
        .rst_n   (rst_in),
        .wr_en   (sample_valid_in),
        .wr_addr (wr_ptr),
        .wr_data (sample_in),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (frame_data_out)
    );

    // Sample side: writes, fill saturation and hop counting run regardless of state.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr   <= '0;
            fill_cnt <= '0;
            hop_cnt  <= '0;
        end else if (sample_valid_in) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (fill_cnt != FILL_FULL) begin
                fill_cnt <= fill_cnt + FW'(1);
            end else if (trig) begin
                hop_cnt <= '0;
            end else begin
                hop_cnt <= hop_cnt + HW'(1);
            end
        end
    end

    // Frame FSM with registered beat flags, busy and overrun.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state           <= IDLE;
            rd_ptr          <= '0;
            rd_cnt          <= '0;
            busy_out        <= 1'b0;
            frame_valid_out <= 1'b0;
            frame_first_out <= 1'b0;
            frame_last_out  <= 1'b0;
            overrun_out     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig_accept) begin
                        state    <= PRIME;
                        busy_out <= 1'b1;
                        // wr_ptr + 1 is the pointer after this cycle's write,
                        // so the window ends on the triggering sample.
                        rd_ptr   <= wr_ptr + AW'(1) - AW'(WINDOW_SIZE);
                        rd_cnt   <= '0;
                    end
                end
                PRIME: begin
                    state <= STREAM;
                end
                STREAM: begin
                    if (last_done) begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
            endcase

            if (rd_en) begin
                rd_ptr          <= rd_ptr + AW'(1);
                rd_cnt          <= rd_cnt + FW'(1);
                frame_valid_out <= 1'b1;
                frame_first_out <= (rd_cnt == '0);
                frame_last_out  <= (rd_cnt == LAST_IDX);
            end else if (beat_done) begin
                frame_valid_out <= 1'b0;
                frame_first_out <= 1'b0;
                frame_last_out  <= 1'b0;
            end

            // A new drop beats a simultaneous clear.
            if (trig_drop) begin
                overrun_out <= 1'b1;
            end else if (clear_overrun_in) begin
                overrun_out <= 1'b0;
            end
        end
    end

`ifdef AUDIO_FRAME_INDEX_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            frame_index_out <= '0;
        end else if (trig_accept) begin
            frame_index_out <= frame_index_out + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_audio_frame_scheduler.sv
// Bench for audio_frame_scheduler with WINDOW_SIZE=8, HOP_SIZE=4.
// A sample-history model predicts every output cycle; directed scenarios add literal checks.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_audio_frame_scheduler;
    import audio_pkg::*;

    localparam int W = 8;
    localparam int H = 4;

    logic    clk = 1'b0;
    logic    rst_n;
    sample_t sample;
    logic    sample_vld;
    logic    enable;
    logic    clear_ovr;
    logic    ready;
    sample_t data;
    logic    valid;
    logic    first;
    logic    last;
    logic    busy;
    logic    ovr;
`ifdef AUDIO_FRAME_INDEX_EN
    logic [15:0] frame_index;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    audio_frame_scheduler #(
        .SAMPLE_WIDTH (16),
        .WINDOW_SIZE  (W),
        .HOP_SIZE     (H)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst_n),
        .sample_in        (sample),
        .sample_valid_in  (sample_vld),
        .enable_in        (enable),
        .clear_overrun_in (clear_ovr),
        .frame_data_out   (data),
        .frame_valid_out  (valid),
        .frame_ready_in   (ready),
        .frame_first_out  (first),
        .frame_last_out   (last),
        .busy_out         (busy),
        .overrun_out      (ovr)
`ifdef AUDIO_FRAME_INDEX_EN
        ,
        .frame_index_out  (frame_index)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int hist[$];     // last W samples written
    int cur[$];      // window of the frame being streamed
    int m_fill, m_hop, m_beat, m_idx;
    bit m_valid, m_busy, m_prime, m_ovr;

    always @(negedge clk) begin
        bit busy_now;
        bit trig;
        if (!rst_n) begin
            chk("rst_valid", valid, 0);
            chk("rst_data",  data,  0);
            chk("rst_first", first, 0);
            chk("rst_last",  last,  0);
            chk("rst_busy",  busy,  0);
            chk("rst_ovr",   ovr,   0);
            hist.delete();
            cur.delete();
            m_fill = 0; m_hop = 0; m_beat = 0; m_idx = 0;
            m_valid = 0; m_busy = 0; m_prime = 0; m_ovr = 0;
        end else begin
            chk("valid",   valid, m_valid);
            chk("busy",    busy,  m_busy);
            chk("overrun", ovr,   m_ovr);
            if (m_valid) begin
                chk("data",  data,  cur[m_beat]);
                chk("first", first, (m_beat == 0));
                chk("last",  last,  (m_beat == W - 1));
`ifdef AUDIO_FRAME_INDEX_EN
                chk("index", frame_index, m_idx);
`endif
            end
            // advance the model across the coming clock edge
            busy_now = m_busy;
            if (m_valid && ready) begin
                m_beat++;
                if (m_beat == W) begin
                    m_valid = 0;
                    m_busy  = 0;
                end
            end
            if (m_prime) begin
                m_prime = 0;
                m_valid = 1;
                m_beat  = 0;
            end
            trig = 0;
            if (sample_vld) begin
                hist.push_back(int'(sample));
                if (hist.size() > W) void'(hist.pop_front());
                if (m_fill < W) begin
                    m_fill++;
                    trig = (m_fill == W);
                end else begin
                    m_hop++;
                    if (m_hop == H) begin
                        trig  = 1;
                        m_hop = 0;
                    end
                end
            end
            if (trig && enable && busy_now) begin
                m_ovr = 1;
            end else begin
                if (clear_ovr) m_ovr = 0;
                if (trig && enable) begin
                    cur     = hist;
                    m_busy  = 1;
                    m_prime = 1;
                    m_idx   = (m_idx + 1) % 65536;
                end
            end
        end
    end

    // Log of accepted beats for the directed checks.
    int got[$];
    always @(negedge clk) begin
        if (rst_n && valid && ready) got.push_back(int'(data));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v, input int gap);
        sample     = sample_t'(v);
        sample_vld = 1'b1;
        tick();
        sample_vld = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        got.delete();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && busy; i++) tick();
        chk("idle_timeout", busy, 0);
        repeat (3) tick();
    endtask

    task automatic expect_frame(input string name, input int base);
        chk({name, "_len"}, got.size(), W);
        for (int i = 0; i < W && i < got.size(); i++) chk(name, got[i], base + i);
    endtask

    bit tog_on = 0;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; sample = '0; sample_vld = 1'b0;
        enable = 1'b1; clear_ovr = 1'b0; ready = 1'b1;

        // 1: first frame 1..8, valid at T+2
        do_reset();
        chk("reset_busy", busy, 0);
        for (int v = 1; v <= 7; v++) send(v, 4);
        send(8, 1);
        chk("lat_t1_valid", valid, 0);
        chk("lat_t1_busy", busy, 1);
        tick();
        chk("lat_t2_valid", valid, 1);
        chk("lat_t2_data", data, 1);
        chk("lat_t2_first", first, 1);
        wait_idle();
        expect_frame("frame1", 1);

        // 2: hops give 5..12 then 9..16
        got.delete();
        for (int v = 9; v <= 12; v++) send(v, 4);
        wait_idle();
        expect_frame("frame2", 5);
        got.delete();
        for (int v = 13; v <= 16; v++) send(v, 4);
        wait_idle();
        expect_frame("frame3", 9);

        // 3: stalls during frame 5..12
        do_reset();
        for (int v = 1; v <= 8; v++) send(v, 4);
        wait_idle();
        got.delete();
        tog_on = 1;
        fork
            begin
                int k = 0;
                while (tog_on) begin
                    ready = pat[k % 4];
                    k++;
                    tick();
                end
            end
        join_none
        for (int v = 9; v <= 12; v++) send(v, 4);
        wait_idle();
        tog_on = 0;
        repeat (2) tick();
        ready = 1'b1;
        expect_frame("stall", 5);

        // 4: overrun while stalled
        do_reset();
        for (int v = 1; v <= 7; v++) send(v, 4);
        ready = 1'b0;
        send(8, 4);
        for (int v = 9; v <= 12; v++) send(v, 4);
        tick();
        chk("ovr_set", ovr, 1);
        chk("ovr_no_beats", got.size(), 0);
        ready = 1'b1;
        wait_idle();
        expect_frame("ovr_frame", 1);
        repeat (6) tick();
        chk("ovr_no_new_frame", got.size(), W);
        chk("ovr_still_set", ovr, 1);
        clear_ovr = 1'b1;
        tick();
        clear_ovr = 1'b0;
        chk("ovr_cleared", ovr, 0);

        // 5: reset during beat 3
        do_reset();
        for (int v = 1; v <= 7; v++) send(v, 4);
        send(8, 1);
        repeat (3) tick();
        chk("beat3_data", data, 3);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_data", data, 0);
        tick();
        rst_n = 1'b1;
        tick();
        got.delete();
        for (int v = 100; v <= 106; v++) send(v, 4);
        chk("refill_no_busy", busy, 0);
        chk("refill_no_beats", got.size(), 0);
        send(107, 4);
        wait_idle();
        expect_frame("refill", 100);

        // 6: enable gating
        do_reset();
        enable = 1'b0;
        for (int v = 1; v <= 12; v++) send(v, 4);
        chk("disabled_no_beats", got.size(), 0);
        enable = 1'b1;
        for (int v = 13; v <= 16; v++) send(v, 4);
        wait_idle();
        expect_frame("enabled", 9);
        chk("enable_no_ovr", ovr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
